// File: rtl/md_scheduler_if.sv
// ---------------------------------------------------------------------------
// md_scheduler_if
//   Bundles the E/D-stage request signals and the HI/LO result signals that
//   pass between the pipeline and the multiply/divide scheduler.
//
//   Request side (driven by the pipeline / master):
//     start     E-stage instruction is a HI/LO op
//     op        1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 0/7 no-op
//     rs_val    forwarded rs operand (dividend / multiplicand / mt data)
//     rt_val    forwarded rt operand (divisor / multiplier)
//     md_use_d  D-stage instruction touches HI/LO
//   Response side (driven by the scheduler / slave):
//     busy      unit occupied
//     stall_md  stall request to the hazard controller
//     hi, lo    HI and LO registers
// ---------------------------------------------------------------------------
interface md_scheduler_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_d;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start,
        output op,
        output rs_val,
        output rt_val,
        output md_use_d,
        input  busy,
        input  stall_md,
        input  hi,
        input  lo
    );

    modport slave (
        input  start,
        input  op,
        input  rs_val,
        input  rt_val,
        input  md_use_d,
        output busy,
        output stall_md,
        output hi,
        output lo
    );
endinterface

// File: rtl/md_scheduler.sv
// ---------------------------------------------------------------------------
// md_scheduler
//   Sequences the multi-cycle multiply/divide unit that sits beside the E
//   stage. One HI/LO operation is accepted per issue; its latency is counted
//   down in a 4-bit counter and the result is committed to HI/LO on the last
//   busy edge. mthi/mtlo write HI/LO directly without occupying the unit.
//   A stall request is raised while a D-stage HI/LO instruction must wait.
//
// Parameters
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
//
// Ports
//   clk    clock, rising edge
//   reset  asynchronous active-low reset
//   md     md_scheduler_if.slave: start/op/rs_val/rt_val/md_use_d in,
//          busy/stall_md/hi/lo out
// ---------------------------------------------------------------------------
module md_scheduler #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           reset,
    md_scheduler_if.slave  md
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state_reg, state_next;
    logic [3:0]  count_reg, count_next;
    logic [2:0]  op_reg,    op_next;
    logic [31:0] a_reg,     a_next;
    logic [31:0] b_reg,     b_next;
    logic [31:0] hi_reg,    hi_next;
    logic [31:0] lo_reg,    lo_next;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic start_md;     // start of a multi-cycle op (1..4)
    logic start_mthi;
    logic start_mtlo;

    assign start_md   = md.start && (md.op >= OP_MULT) && (md.op <= OP_DIVU);
    assign start_mthi = md.start && (md.op == OP_MTHI);
    assign start_mtlo = md.start && (md.op == OP_MTLO);

    // ------------------------------------------------------------------
    // Single-step datapath working only from the latched operands, so the
    // forwarded rs/rt values are free to change while the unit is busy.
    // ------------------------------------------------------------------
    logic        op_signed;
    logic        op_is_mult;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;

    assign op_signed  = (op_reg == OP_MULT) || (op_reg == OP_DIV);
    assign op_is_mult = (op_reg == OP_MULT) || (op_reg == OP_MULTU);

    // Sign- or zero-extend to 64 bits; the low 64 bits of the extended
    // product equal the exact signed/unsigned 32x32 product.
    assign a_ext   = {{32{op_signed & a_reg[31]}}, a_reg};
    assign b_ext   = {{32{op_signed & b_reg[31]}}, b_reg};
    assign product = a_ext * b_ext;

    // Division on magnitudes, then sign fix-up: quotient truncates toward
    // zero, remainder takes the dividend's sign. 0x80000000 / -1 falls out
    // naturally as quotient 0x80000000, remainder 0.
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        div_by_zero;
    logic [31:0] b_safe;
    logic [31:0] uquot;
    logic [31:0] urem;
    logic [31:0] quot;
    logic [31:0] rem;

    assign a_neg       = op_signed & a_reg[31];
    assign b_neg       = op_signed & b_reg[31];
    assign a_mag       = a_neg ? (~a_reg + 32'd1) : a_reg;
    assign b_mag       = b_neg ? (~b_reg + 32'd1) : b_reg;
    assign div_by_zero = (b_reg == 32'd0);
    // Keep the divider input defined when the divisor is zero; the result
    // is discarded in that case anyway.
    assign b_safe      = div_by_zero ? 32'd1 : b_mag;
    assign uquot       = a_mag / b_safe;
    assign urem        = a_mag % b_safe;
    assign quot        = (a_neg ^ b_neg) ? (~uquot + 32'd1) : uquot;
    assign rem         = a_neg ? (~urem + 32'd1) : urem;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= 4'd0;
            op_reg    <= 3'd0;
            a_reg     <= 32'd0;
            b_reg     <= 32'd0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        op_next    = op_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;

        unique case (state_reg)
            IDLE: begin
                if (start_md) begin
                    op_next    = md.op;
                    a_next     = md.rs_val;
                    b_next     = md.rt_val;
                    count_next = ((md.op == OP_MULT) || (md.op == OP_MULTU))
                                 ? MULT_LOAD : DIV_LOAD;
                    state_next = BUSY;
                end else if (start_mthi) begin
                    hi_next = md.rs_val;
                end else if (start_mtlo) begin
                    lo_next = md.rs_val;
                end
            end

            BUSY: begin
                // Any start seen here is ignored: the in-flight op owns the
                // unit until its commit edge.
                count_next = count_reg - 4'd1;
                if (count_reg == 4'd1) begin
                    state_next = IDLE;
                    if (op_is_mult) begin
                        hi_next = product[63:32];
                        lo_next = product[31:0];
                    end else if (!div_by_zero) begin
                        hi_next = rem;
                        lo_next = quot;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The start cycle already reads as busy so the instruction behind it in
    // D stalls. Gating with reset keeps busy/stall low while reset is held,
    // even if the pipeline still presents a start.
    logic busy_int;

    assign busy_int    = reset && ((state_reg == BUSY) || start_md);
    assign md.busy     = busy_int;
    assign md.stall_md = md.md_use_d && busy_int;
    assign md.hi       = hi_reg;
    assign md.lo       = lo_reg;

endmodule

// File: tb/tb_md_scheduler.sv
// ---------------------------------------------------------------------------
// tb_md_scheduler
//   Self-checking bench for md_scheduler. Expected HI/LO results and busy
//   lengths are pushed to a scoreboard queue when an op is issued and popped
//   when the unit drops busy.
// ---------------------------------------------------------------------------
module tb_md_scheduler;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk;
    logic reset;

    md_scheduler_if md_bus ();

    md_scheduler #(
        .MULT_CYCLES (MC),
        .DIV_CYCLES  (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .md    (md_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;

    // Reference behaviour using 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] h0,
                                          input logic [31:0] l0);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     r;
        r = {h0, l0};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd1: r = sa * sb;
            3'd2: r = ua * ub;
            3'd3: if (b != 32'd0) begin
                      sq = sa / sb;
                      sr = sa % sb;
                      r  = {sr[31:0], sq[31:0]};
                  end
            3'd4: if (b != 32'd0) begin
                      r = {32'(ua % ub), 32'(ua / ub)};
                  end
            default: r = {h0, l0};
        endcase
        return r;
    endfunction

    // Drive one start cycle; report busy/stall seen in that cycle. Returns
    // just after the sampling edge, with operands scrambled.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output logic sb,
                         output logic ss);
        @(posedge clk);
        #1;
        md_bus.start  = 1'b1;
        md_bus.op     = op;
        md_bus.rs_val = a;
        md_bus.rt_val = b;
        @(negedge clk);
        sb = md_bus.busy;
        ss = md_bus.stall_md;
        @(posedge clk);
        #1;
        md_bus.start  = 1'b0;
        md_bus.op     = 3'd0;
        md_bus.rs_val = $urandom;
        md_bus.rt_val = $urandom;
    endtask

    // Count busy cycles after the start edge, flagging any HI/LO change
    // while still busy.
    task automatic wait_idle(output int cycles, output bit timeout,
                             output bit early);
        logic [31:0] h0, l0;
        h0 = md_bus.hi;
        l0 = md_bus.lo;
        cycles  = 0;
        timeout = 1'b1;
        early   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_bus.busy !== 1'b1) begin
                timeout = 1'b0;
                break;
            end
            if (md_bus.hi !== h0 || md_bus.lo !== l0) early = 1'b1;
            cycles++;
        end
    endtask

    // Issue one multi-cycle op and check it against the scoreboard head.
    task automatic run_md(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        logic sb, ss;
        int   cyc;
        bit   to, early;
        exp_t e;
        issue(op, a, b, sb, ss);
        wait_idle(cyc, to, early);
        e = exp_q.pop_front();
        total++;
        if (sb !== 1'b1) begin
            bad++;
            $display("FAIL %s start_busy got=%b want=1", name, sb);
        end
        total++;
        if (to || cyc != e.n) begin
            bad++;
            $display("FAIL %s busy_cycles got=%0d want=%0d timeout=%0b", name, cyc, e.n, to);
        end
        total++;
        if (early) begin
            bad++;
            $display("FAIL %s early_commit got=1 want=0", name);
        end
        total++;
        if (md_bus.hi !== e.hi || md_bus.lo !== e.lo) begin
            bad++;
            $display("FAIL %s result got hi=%h lo=%h want hi=%h lo=%h",
                     name, md_bus.hi, md_bus.lo, e.hi, e.lo);
        end
        model_hi = e.hi;
        model_lo = e.lo;
        $display("%s op=%0d rs=%h rt=%h -> hi=%h lo=%h cycles=%0d",
                 name, op, a, b, md_bus.hi, md_bus.lo, cyc);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (md_bus.busy !== 1'b0 || md_bus.stall_md !== 1'b0 ||
            md_bus.hi !== 32'd0 || md_bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL reset_state got busy=%b stall=%b hi=%h lo=%h want 0",
                     md_bus.busy, md_bus.stall_md, md_bus.hi, md_bus.lo);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (md_bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_busy got=%b want=0", md_bus.busy);
        end
        $display("reset released");
    endtask

    task automatic test_mult();
        exp_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFF1, n: MC});
        run_md("mult_neg", 3'd1, 32'hFFFFFFFD, 32'd5);
        exp_q.push_back('{hi: 32'hFFFFFFFE, lo: 32'h00000001, n: MC});
        run_md("multu_max", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    endtask

    task automatic test_div();
        exp_q.push_back('{hi: 32'd2, lo: 32'd14, n: DC});
        run_md("divu_100_7", 3'd4, 32'd100, 32'd7);
        exp_q.push_back('{hi: 32'd0, lo: 32'h80000000, n: DC});
        run_md("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF);
        exp_q.push_back('{hi: 32'hFFFFFFFF, lo: 32'hFFFFFFFD, n: DC});
        run_md("div_m7_2", 3'd3, 32'hFFFFFFF9, 32'd2);
    endtask

    task automatic test_mt_divzero();
        logic sb, ss;
        logic [31:0] lo_before;
        lo_before = md_bus.lo;
        issue(3'd5, 32'h00001234, 32'hDEAD0000, sb, ss);
        @(negedge clk);
        total++;
        if (sb !== 1'b0 || md_bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL mthi_busy got start=%b after=%b want 0", sb, md_bus.busy);
        end
        total++;
        if (md_bus.hi !== 32'h00001234 || md_bus.lo !== lo_before) begin
            bad++;
            $display("FAIL mthi_value got hi=%h lo=%h want hi=00001234 lo=%h",
                     md_bus.hi, md_bus.lo, lo_before);
        end
        model_hi = 32'h00001234;
        $display("mthi rs=00001234 -> hi=%h lo=%h", md_bus.hi, md_bus.lo);
        exp_q.push_back('{hi: 32'h00001234, lo: lo_before, n: DC});
        run_md("div_by_zero", 3'd3, 32'd77, 32'd0);
        issue(3'd6, 32'hCAFEF00D, 32'd0, sb, ss);
        @(negedge clk);
        total++;
        if (md_bus.lo !== 32'hCAFEF00D || md_bus.hi !== 32'h00001234 || sb !== 1'b0) begin
            bad++;
            $display("FAIL mtlo_value got hi=%h lo=%h busy=%b want hi=00001234 lo=cafef00d busy=0",
                     md_bus.hi, md_bus.lo, sb);
        end
        model_lo = 32'hCAFEF00D;
        $display("mtlo rs=cafef00d -> hi=%h lo=%h", md_bus.hi, md_bus.lo);
        exp_q.push_back('{hi: 32'h00001234, lo: 32'hCAFEF00D, n: DC});
        run_md("divu_by_zero", 3'd4, 32'd5, 32'd0);
    endtask

    task automatic test_stall();
        logic sb, ss;
        int   stall_cnt;
        logic [63:0] r;
        r = model(3'd1, 32'd7, 32'hFFFFFFFA, model_hi, model_lo);
        md_bus.md_use_d = 1'b1;
        issue(3'd1, 32'd7, 32'hFFFFFFFA, sb, ss);
        total++;
        if (ss !== 1'b1) begin
            bad++;
            $display("FAIL stall_start got=%b want=1", ss);
        end
        stall_cnt = 0;
        for (int i = 0; i < MC; i++) begin
            @(negedge clk);
            if (md_bus.stall_md === 1'b1) stall_cnt++;
        end
        total++;
        if (stall_cnt != MC) begin
            bad++;
            $display("FAIL stall_busy_cycles got=%0d want=%0d", stall_cnt, MC);
        end
        @(negedge clk);
        total++;
        if (md_bus.stall_md !== 1'b0 || md_bus.hi !== r[63:32] || md_bus.lo !== r[31:0]) begin
            bad++;
            $display("FAIL stall_release got stall=%b hi=%h lo=%h want stall=0 hi=%h lo=%h",
                     md_bus.stall_md, md_bus.hi, md_bus.lo, r[63:32], r[31:0]);
        end
        model_hi = r[63:32];
        model_lo = r[31:0];
        md_bus.md_use_d = 1'b0;
        $display("mult_stall rs=7 rt=-6 -> hi=%h lo=%h stall_cycles=%0d",
                 md_bus.hi, md_bus.lo, stall_cnt);
    endtask

    task automatic test_start_while_busy();
        logic sb, ss;
        int   cnt;
        bit   to;
        logic [63:0] r;
        r = model(3'd1, 32'h12345678, 32'h9ABCDEF0, model_hi, model_lo);
        issue(3'd1, 32'h12345678, 32'h9ABCDEF0, sb, ss);
        cnt = 0;
        to  = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (md_bus.busy !== 1'b1) begin
                to = 1'b0;
                break;
            end
            cnt++;
            if (i == 1) begin
                md_bus.start  = 1'b1;
                md_bus.op     = 3'd4;
                md_bus.rs_val = 32'd100;
                md_bus.rt_val = 32'd7;
            end else if (i == 2) begin
                md_bus.start = 1'b0;
                md_bus.op    = 3'd0;
            end
        end
        total++;
        if (to || cnt != MC) begin
            bad++;
            $display("FAIL ignore_busy_cycles got=%0d want=%0d timeout=%0b", cnt, MC, to);
        end
        total++;
        if (md_bus.hi !== r[63:32] || md_bus.lo !== r[31:0]) begin
            bad++;
            $display("FAIL ignore_result got hi=%h lo=%h want hi=%h lo=%h",
                     md_bus.hi, md_bus.lo, r[63:32], r[31:0]);
        end
        @(negedge clk);
        total++;
        if (md_bus.busy !== 1'b0 || md_bus.hi !== r[63:32] || md_bus.lo !== r[31:0]) begin
            bad++;
            $display("FAIL ignore_after got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h",
                     md_bus.busy, md_bus.hi, md_bus.lo, r[63:32], r[31:0]);
        end
        model_hi = r[63:32];
        model_lo = r[31:0];
        $display("mult_with_ignored_divu -> hi=%h lo=%h cycles=%0d", md_bus.hi, md_bus.lo, cnt);
    endtask

    task automatic test_async_reset();
        logic sb, ss;
        logic [63:0] r;
        md_bus.md_use_d = 1'b1;
        issue(3'd3, 32'hFFFFFF9C, 32'd3, sb, ss);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if (md_bus.busy !== 1'b0 || md_bus.stall_md !== 1'b0 ||
            md_bus.hi !== 32'd0 || md_bus.lo !== 32'd0) begin
            bad++;
            $display("FAIL async_reset got busy=%b stall=%b hi=%h lo=%h want 0",
                     md_bus.busy, md_bus.stall_md, md_bus.hi, md_bus.lo);
        end
        $display("async reset in div busy cycle 3 -> hi=%h lo=%h", md_bus.hi, md_bus.lo);
        md_bus.md_use_d = 1'b0;
        model_hi = 32'd0;
        model_lo = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (md_bus.busy !== 1'b0 || md_bus.hi !== 32'd0) begin
            bad++;
            $display("FAIL post_reset_idle got busy=%b hi=%h want busy=0 hi=0",
                     md_bus.busy, md_bus.hi);
        end
        r = model(3'd1, 32'd1000, 32'hFFFFFC18, model_hi, model_lo);
        exp_q.push_back('{hi: r[63:32], lo: r[31:0], n: MC});
        run_md("mult_after_reset", 3'd1, 32'd1000, 32'hFFFFFC18);
    endtask

    task automatic test_random_ops();
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] r;
        for (int k = 0; k < 10; k++) begin
            op = 3'($urandom_range(1, 4));
            a  = $urandom;
            b  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom);
            if (k == 3) b = 32'd1;
            r  = model(op, a, b, model_hi, model_lo);
            exp_q.push_back('{hi: r[63:32], lo: r[31:0],
                              n: (op <= 3'd2) ? MC : DC});
            run_md("rand", op, a, b);
        end
    endtask

    initial begin
        reset           = 1'b0;
        md_bus.start    = 1'b0;
        md_bus.op       = 3'd0;
        md_bus.rs_val   = 32'd0;
        md_bus.rt_val   = 32'd0;
        md_bus.md_use_d = 1'b0;

        test_reset();
        test_mult();
        test_div();
        test_mt_divzero();
        test_stall();
        test_start_while_busy();
        test_async_reset();
        test_random_ops();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
